// File: rtl/wb_pkg.sv
// Shared widths, default depth and the queued writeback entry type.
package wb_pkg;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match lookup of one register read address across the occupied queue slots.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] query,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (query != '0) && (entries[idx].addr == query)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue in front of the register file write port, with read forwarding.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  input  logic              flush,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full || drain_en;

  // Writes to r0 are acknowledged but never occupy a slot.
  assign push = in_valid && in_ready && !flush && (in_addr != '0);
  assign pop  = WE3 && !flush;

  assign WE3 = !empty && drain_en;
  assign A3  = empty ? '0 : mem[head].addr;
  assign WD3 = empty ? '0 : mem[head].data;

  // Flush wins over push and pop; an empty count also hides the unreset entry data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail].addr <= in_addr;
      mem[tail].data <= in_data;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd1 (
    .entries (mem),
    .head    (head),
    .count   (count_q),
    .query   (A1),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd2 (
    .entries (mem),
    .head    (head),
    .count   (count_q),
    .query   (A2),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue with hand-computed expectations.
module tb_wb_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        flush;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int compared;
  int mismatched;

  wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .flush     (flush),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .A1        (A1),
    .A2        (A2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                               input logic dr, input logic fl);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = dr;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  drain_addr [4];
  logic [31:0] drain_data [4];

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    A1         = 5'd0;
    A2         = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #20;
    checkOutput("rst_we3", {31'b0, WE3}, 32'd0);
    checkOutput("rst_count", {29'b0, count}, 32'd0);
    checkOutput("rst_empty", {31'b0, empty}, 32'd1);
    checkOutput("rst_full", {31'b0, full}, 32'd0);
    checkOutput("rst_a3", {27'b0, A3}, 32'd0);
    checkOutput("rst_fwd1", {31'b0, fwd1_hit}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick();

    // Single push, retire one cycle later; forwarding ignores the in-flight request.
    A1 = 5'd3;
    applyStimulus(1'b1, 5'd3, 32'hAAAA0001, 1'b1, 1'b0);
    checkOutput("lat_we3_before", {31'b0, WE3}, 32'd0);
    checkOutput("fwd_ignores_in", {31'b0, fwd1_hit}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("lat_we3", {31'b0, WE3}, 32'd1);
    checkOutput("lat_a3", {27'b0, A3}, 32'd3);
    checkOutput("lat_wd3", WD3, 32'hAAAA0001);
    checkOutput("lat_fwd1_data", fwd1_data, 32'hAAAA0001);
    tick();
    checkOutput("lat_empty", {31'b0, empty}, 32'd1);
    checkOutput("lat_we3_after", {31'b0, WE3}, 32'd0);
    checkOutput("lat_wd3_empty", WD3, 32'd0);

    // Fill to full with pointers wrapping, then push-and-pop while full.
    A1 = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd6, 32'h106, 1'b0, 1'b0);
    checkOutput("full_flag", {31'b0, full}, 32'd1);
    checkOutput("full_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("full_count", {29'b0, count}, 32'd4);
    applyStimulus(1'b1, 5'd6, 32'h106, 1'b1, 1'b0);
    checkOutput("full_ready_drain", {31'b0, in_ready}, 32'd1);
    checkOutput("full_head_a3", {27'b0, A3}, 32'd1);
    checkOutput("full_head_wd3", WD3, 32'h101);
    tick();
    checkOutput("pushpop_count", {29'b0, count}, 32'd4);
    drain_addr = '{5'd2, 5'd3, 5'd4, 5'd6};
    drain_data = '{32'h102, 32'h103, 32'h104, 32'h106};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("drain_a3_%0d", i), {27'b0, A3}, {27'b0, drain_addr[i]});
      checkOutput($sformatf("drain_wd3_%0d", i), WD3, drain_data[i]);
      tick();
    end
    checkOutput("drain_empty", {31'b0, empty}, 32'd1);

    // Youngest-match forwarding on two writes to the same register.
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 32'h22, 1'b0, 1'b0);
    tick();
    A1 = 5'd5;
    A2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("fwd1_hit", {31'b0, fwd1_hit}, 32'd1);
    checkOutput("fwd1_young", fwd1_data, 32'h22);
    checkOutput("fwd2_r0_hit", {31'b0, fwd2_hit}, 32'd0);
    checkOutput("fwd2_r0_data", fwd2_data, 32'd0);
    A1 = 5'd7;
    A2 = 5'd5;
    #1;
    checkOutput("fwd1_miss", {31'b0, fwd1_hit}, 32'd0);
    checkOutput("fwd2_hit", {31'b0, fwd2_hit}, 32'd1);
    checkOutput("fwd2_young", fwd2_data, 32'h22);

    // r0 write is acknowledged but never queued or retired.
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
    checkOutput("r0_ready", {31'b0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("r0_count", {29'b0, count}, 32'd2);
    A1 = 5'd0;
    A2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("r0_drain0", WD3, 32'h11);
    tick();
    checkOutput("r0_drain1", WD3, 32'h22);
    tick();
    checkOutput("r0_no_write", {31'b0, WE3}, 32'd0);

    // Flush with a concurrent push: WE3 still reflects the head, then everything is gone.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd7 + 5'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd10, 32'h10A, 1'b1, 1'b1);
    checkOutput("flush_count_pre", {29'b0, count}, 32'd3);
    checkOutput("flush_we3", {31'b0, WE3}, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_count", {29'b0, count}, 32'd0);
    checkOutput("flush_empty", {31'b0, empty}, 32'd1);
    checkOutput("flush_lost", {31'b0, WE3}, 32'd0);

    // Asynchronous reset between edges drops pending entries.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'd12 + 5'(i), 32'h300 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("arst_we3_pre", {31'b0, WE3}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_we3", {31'b0, WE3}, 32'd0);
    checkOutput("arst_count", {29'b0, count}, 32'd0);
    checkOutput("arst_empty", {31'b0, empty}, 32'd1);
    tick();
    #2;
    reset = 1'b1;
    tick();
    checkOutput("arst_no_stale", {31'b0, WE3}, 32'd0);
    checkOutput("arst_count_post", {29'b0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queued writeback entries (power of two, 2..16).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low; clears all queue state.
REQ-005 in_valid  in  1  producer offers a writeback request.
REQ-006 in_ready  out  1  queue can accept the request this cycle.
REQ-007 in_addr  in  5  destination register index.
REQ-008 in_data  in  32  value to write.
REQ-009 drain_en  in  1  register file write port available; head may retire this cycle.
REQ-010 flush  in  1  synchronous discard of all queued entries.
REQ-011 WE3  out  1  write enable to the register file.
REQ-012 A3  out  5  write address to the register file.
REQ-013 WD3  out  32  write data to the register file.
REQ-014 A1, A2  in  5 each  read addresses currently presented to the register file.
REQ-015 fwd1_hit, fwd2_hit  out  1 each  a queued entry targets A1 or A2.
REQ-016 fwd1_data, fwd2_data  out  32 each  newest queued value for A1 or A2.
REQ-017 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-018 full, empty  out  1 each  occupancy flags.

Function
REQ-019 Storage SHALL be an in-order circular FIFO; head is the oldest entry.
REQ-020 Accept SHALL occur on a rising edge with in_valid & in_ready & !flush.
REQ-021 Requests with in_addr == 0 SHALL be accepted and discarded; they are never enqueued and never forwarded.
REQ-022 in_ready SHALL be !full | drain_en: a push while full is allowed only in the same cycle as a pop.
REQ-023 WE3 SHALL be !empty & drain_en, combinational, with A3/WD3 driven from the head entry.
REQ-024 A3 and WD3 SHALL be 0 when empty.
REQ-025 The head SHALL pop on a rising edge with WE3 == 1; one retire per cycle maximum.
REQ-026 Write latency SHALL be one cycle minimum: data accepted at edge N appears on WE3/A3/WD3 in cycle N+1 if drain_en is high.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-028 fwdX_hit SHALL be 1 when AX != 0 and any valid entry has addr == AX; fwdX_data SHALL be the youngest matching entry's data, else 0.
REQ-029 Forwarding SHALL be combinational and SHALL NOT consider the in_* request of the current cycle.
REQ-030 flush SHALL empty the queue at the next edge and take priority over push and pop; WE3 SHALL still follow REQ-023 during the flush cycle.
REQ-031 full SHALL be count == DEPTH; empty SHALL be count == 0.

Reset
REQ-032 While reset is low, the block SHALL immediately drive WE3=0, A3=0, WD3=0, count=0, empty=1, full=0, fwd*_hit=0 and fwd*_data=0, with pointers cleared.
REQ-033 Reset asserted mid-operation SHALL drop all pending entries without retiring them.
REQ-034 Entry data SHALL NOT need reset; only valid state and pointers are reset.

Structure
REQ-035 Package wb_pkg SHALL hold ADDR_W=5, DATA_W=32, DEPTH_DEFAULT=4, and the entry struct {addr, data}.
REQ-036 The youngest-match forwarding search SHALL be one sub-module, wb_fwd_match, instantiated twice (A1 and A2).

Verification
REQ-037 Push (3,0xAAAA0001) with drain_en=1 -> next cycle WE3=1, A3=3, WD3=0xAAAA0001; then empty=1.
REQ-038 drain_en=0, push 4 entries -> full=1, in_ready=0; a fifth push with drain_en=1 is accepted, pops the head, and count stays 4.
REQ-039 Queue (5,0x11), then (5,0x22), with A1=5 -> fwd1_hit=1, fwd1_data=0x22; with A2=0 -> fwd2_hit=0.
REQ-040 Push (0,0xDEAD) -> count unchanged, no WE3 is ever issued for it.
REQ-041 Three entries queued, flush=1 with a concurrent push -> next cycle count=0 and empty=1; the pushed entry is lost.
REQ-042 Two entries queued, reset pulled low asynchronously between edges -> WE3=0 and count=0 immediately; after release, no stale write is issued.
